// File: rtl/regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_ctrl
// Description : Register-file initiator. It streams all registers out over a
//               valid/ready port (dump), or it writes registers 1..2**R-1 from
//               an input stream (load).
//               Define REGFILE_DUMP_ADDR_EN to add the dout_addr output.
// Revision    : 1.0  initial release
// ============================================================================
module regfile_dump_ctrl #(
    parameter int N = 16,
    parameter int R = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_dump,
    input  logic         start_load,
    output logic         busy,
    output logic         done,
    output logic [R-1:0] ra,
    input  logic [N-1:0] rd,
    output logic         we,
    output logic [R-1:0] wa,
    output logic [N-1:0] wd,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic [N-1:0] dout_data,
`ifdef REGFILE_DUMP_ADDR_EN
    output logic [R-1:0] dout_addr,
`endif
    input  logic         din_valid,
    output logic         din_ready,
    input  logic [N-1:0] din_data
);

    localparam int           DEPTH  = 1 << R;
    localparam logic [R-1:0] c_LAST = R'(DEPTH - 1);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_DUMP_RD  = 3'd1;
    localparam logic [2:0] c_DUMP_OUT = 3'd2;
    localparam logic [2:0] c_LOAD     = 3'd3;
    localparam logic [2:0] c_FIN      = 3'd4;

    logic [2:0]   r_state;
    logic [R-1:0] r_idx;
    logic         r_we;
    logic [R-1:0] r_wa;
    logic [N-1:0] r_wd;
    logic [N-1:0] r_dout_data;
`ifdef REGFILE_DUMP_ADDR_EN
    logic [R-1:0] r_dout_addr;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_idx       <= '0;
            r_we        <= 1'b0;
            r_wa        <= '0;
            r_wd        <= '0;
            r_dout_data <= '0;
`ifdef REGFILE_DUMP_ADDR_EN
            r_dout_addr <= '0;
`endif
        end else begin
            r_we <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start_dump) begin
                        r_state <= c_DUMP_RD;
                        r_idx   <= '0;
                    end else if (start_load) begin
                        r_state <= c_LOAD;
                        r_idx   <= R'(1);
                    end
                end
                c_DUMP_RD: begin
                    r_dout_data <= rd;
`ifdef REGFILE_DUMP_ADDR_EN
                    r_dout_addr <= r_idx;
`endif
                    r_state     <= c_DUMP_OUT;
                end
                c_DUMP_OUT: begin
                    if (dout_ready) begin
                        // Last-index test precedes the increment so idx never wraps.
                        if (r_idx == c_LAST) begin
                            r_state <= c_FIN;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= c_DUMP_RD;
                        end
                    end
                end
                c_LOAD: begin
                    if (din_valid) begin
                        r_we <= 1'b1;
                        r_wa <= r_idx;
                        r_wd <= din_data;
                        if (r_idx == c_LAST) begin
                            r_state <= c_FIN;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                c_FIN: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy       = (r_state != c_IDLE);
    assign done       = (r_state == c_FIN);
    assign dout_valid = (r_state == c_DUMP_OUT);
    assign din_ready  = (r_state == c_LOAD);
    assign ra         = r_idx;
    assign we         = r_we;
    assign wa         = r_wa;
    assign wd         = r_wd;
    assign dout_data  = r_dout_data;
`ifdef REGFILE_DUMP_ADDR_EN
    assign dout_addr  = r_dout_addr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_dump_ctrl
// Description : Self-checking bench for regfile_dump_ctrl with a behavioural
//               register file (combinational read, r0 reads zero).
// Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_dump_ctrl;

    logic        clk;
    logic        reset;
    logic        start_dump;
    logic        start_load;
    logic        busy;
    logic        done;
    logic [2:0]  ra;
    logic [15:0] rd;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        dout_valid;
    logic        dout_ready;
    logic [15:0] dout_data;
`ifdef REGFILE_DUMP_ADDR_EN
    logic [2:0]  dout_addr;
`endif
    logic        din_valid;
    logic        din_ready;
    logic [15:0] din_data;

    regfile_dump_ctrl #(.N(16), .R(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_dump (start_dump),
        .start_load (start_load),
        .busy       (busy),
        .done       (done),
        .ra         (ra),
        .rd         (rd),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data),
`ifdef REGFILE_DUMP_ADDR_EN
        .dout_addr  (dout_addr),
`endif
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_data   (din_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model; the bench preloads it through a private port.
    logic [15:0] mem [0:7];
    logic        pre_we;
    logic [2:0]  pre_wa;
    logic [15:0] pre_wd;
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        else if (pre_we) mem[pre_wa] <= pre_wd;
    end
    assign rd = (ra == 3'd0) ? 16'h0000 : mem[ra];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int hs_count = 0;
    logic [15:0] beats [$];
    logic [2:0]  addrs [$];
    logic [2:0]  we_wa [$];
    logic [15:0] we_wd [$];
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = 16'h0;
    logic [15:0] exp_dump [8];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (prev_stall) begin
            checks++;
            if (!(dout_valid && dout_data == prev_data)) begin
                errors++;
                $display("FAIL dout_hold: valid=%0b data=0x%0h required valid=1 data=0x%0h",
                         dout_valid, dout_data, prev_data);
            end
        end
        prev_stall = dout_valid && !dout_ready;
        prev_data  = dout_data;
        if (dout_valid && dout_ready) begin
            beats.push_back(dout_data);
`ifdef REGFILE_DUMP_ADDR_EN
            addrs.push_back(dout_addr);
`endif
        end
        if (we) begin
            we_wa.push_back(wa);
            we_wd.push_back(wd);
        end
        if (din_valid && din_ready) hs_count++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_we"}, {31'd0, we}, 32'd0);
        check({tag, "_dout_valid"}, {31'd0, dout_valid}, 32'd0);
        check({tag, "_din_ready"}, {31'd0, din_ready}, 32'd0);
        check({tag, "_ra"}, {29'd0, ra}, 32'd0);
        check({tag, "_wa"}, {29'd0, wa}, 32'd0);
        check({tag, "_wd"}, {16'd0, wd}, 32'd0);
        check({tag, "_dout_data"}, {16'd0, dout_data}, 32'd0);
    endtask

    // mode 0: plain dump, 1: word 3 stalled 5 cycles, 2: both starts + start_load mid-dump
    task automatic do_dump(input string tag, input int mode);
        int d0;
        int c0;
        bit stalled;
        stalled = 1'b0;
        beats.delete();
        addrs.delete();
        we_wa.delete();
        dout_ready = 1'b1;
        d0 = done_cnt;
        c0 = cyc;
        start_dump = 1'b1;
        start_load = (mode == 2);
        tick();
        start_dump = 1'b0;
        start_load = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        for (int t = 0; t < 200 && done_cnt == d0; t++) begin
            if (mode == 1 && beats.size() == 3 && !stalled) begin
                stalled = 1'b1;
                dout_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check({tag, "_stall_valid"}, {31'd0, dout_valid}, 32'd1);
                    check({tag, "_stall_data"}, {16'd0, dout_data}, {16'd0, exp_dump[3]});
                end
                dout_ready = 1'b1;
            end
            start_load = (mode == 2 && beats.size() == 4);
            tick();
        end
        start_load = 1'b0;
        check({tag, "_done_pulses"}, done_cnt - d0, 32'd1);
        // start sampled one edge after c0, done visible 16 edges later
        if (mode != 1) check({tag, "_latency"}, done_cyc - c0, 32'd17);
        check({tag, "_beats"}, beats.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < beats.size())
                check({tag, "_data"}, {16'd0, beats[i]}, {16'd0, exp_dump[i]});
`ifdef REGFILE_DUMP_ADDR_EN
            if (i < addrs.size())
                check({tag, "_addr"}, {29'd0, addrs[i]}, i);
`endif
        end
        repeat (3) tick();
        check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
        check({tag, "_no_we"}, we_wa.size(), 32'd0);
    endtask

    typedef struct {
        logic [15:0] din;
        logic [2:0]  exp_wa;
        logic [15:0] exp_wd;
    } load_vec_t;
    load_vec_t lv [7];

    initial begin
        int k;
        int d0;
        lv[0] = '{16'hA001, 3'd1, 16'hA001};
        lv[1] = '{16'hA002, 3'd2, 16'hA002};
        lv[2] = '{16'hA003, 3'd3, 16'hA003};
        lv[3] = '{16'hA004, 3'd4, 16'hA004};
        lv[4] = '{16'hA005, 3'd5, 16'hA005};
        lv[5] = '{16'hA006, 3'd6, 16'hA006};
        lv[6] = '{16'hA007, 3'd7, 16'hA007};

        reset = 1'b1;
        start_dump = 1'b0;
        start_load = 1'b0;
        dout_ready = 1'b0;
        din_valid = 1'b0;
        din_data = 16'h0;
        pre_we = 1'b0;
        pre_wa = 3'd0;
        pre_wd = 16'h0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_idle("reset");

        for (int i = 1; i < 8; i++) begin
            pre_we = 1'b1;
            pre_wa = 3'(i);
            pre_wd = 16'(16'h1111 * i);
            tick();
        end
        pre_we = 1'b0;

        // Dump of preset contents
        for (int i = 0; i < 8; i++) exp_dump[i] = 16'(16'h1111 * i);
        do_dump("dump_preset", 0);

        // Load from the vector table
        we_wa.delete();
        we_wd.delete();
        hs_count = 0;
        d0 = done_cnt;
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        k = 0;
        din_valid = 1'b1;
        din_data = lv[0].din;
        for (int t = 0; t < 100 && k < 7; t++) begin
            tick();
            if (hs_count > k) begin
                k = hs_count;
                if (k < 7) din_data = lv[k].din;
            end
        end
        din_valid = 1'b0;
        for (int t = 0; t < 20 && done_cnt == d0; t++) tick();
        check("load_done_pulses", done_cnt - d0, 32'd1);
        check("load_we_pulses", we_wa.size(), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < we_wa.size()) begin
                check("load_wa", {29'd0, we_wa[i]}, {29'd0, lv[i].exp_wa});
                check("load_wd", {16'd0, we_wd[i]}, {16'd0, lv[i].exp_wd});
            end
        end
        check("load_idle_after", {31'd0, busy}, 32'd0);

        exp_dump[0] = 16'h0000;
        for (int i = 1; i < 8; i++) exp_dump[i] = lv[i-1].exp_wd;
        do_dump("dump_loaded", 0);
        do_dump("dump_stall", 1);
        do_dump("dump_both", 2);

        // Reset right after the third load handshake
        we_wa.delete();
        we_wd.delete();
        hs_count = 0;
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        din_valid = 1'b1;
        din_data = 16'hB001;
        for (int t = 0; t < 50 && hs_count < 3; t++) begin
            tick();
            din_data = 16'(16'hB001 + hs_count);
        end
        reset = 1'b1;
        din_valid = 1'b0;
        tick();
        check_idle("abort");
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check("abort_we_pulses", we_wa.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < we_wa.size()) begin
                check("abort_wa", {29'd0, we_wa[i]}, i + 1);
                check("abort_wd", {16'd0, we_wd[i]}, 32'hB001 + i);
            end
        end
        check("abort_idle", {31'd0, busy}, 32'd0);

        exp_dump[0] = 16'h0000;
        exp_dump[1] = 16'hB001;
        exp_dump[2] = 16'hB002;
        exp_dump[3] = 16'hB003;
        exp_dump[4] = 16'hA004;
        exp_dump[5] = 16'hA005;
        exp_dump[6] = 16'hA006;
        exp_dump[7] = 16'hA007;
        do_dump("dump_after_abort", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
